hazard_stall_controller: RTL and testbench
==========================================

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 Parameter MEM_CYCLES, default 4: total cycles one load/store stays in MEM stage; legal range 1..255.
REQ-002 clock  input  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 src1, src2  input  5 each  ID-stage source register numbers.
REQ-005 two_regs  input  1  ID instruction reads src2 (src2 participates in hazard check).
REQ-006 exe_dest  input  5  EXE-stage destination; exe_wb_en  input  1  EXE writes back; exe_mem_read  input  1  EXE instruction is a load.
REQ-007 mem_dest  input  5  MEM-stage destination; mem_wb_en  input  1  MEM writes back.
REQ-008 mem_stage_read, mem_stage_write  input  1 each  MEM-stage instruction accesses data memory.
REQ-009 branch_taken  input  1  EXE-stage branch resolved taken.
REQ-010 forward_en  input  1  forwarding unit active.
REQ-011 freez_front  output  1  hold PC and IF/ID register.
REQ-012 flush_ifid  output  1  clear IF/ID register.
REQ-013 flush_idexe  output  1  clear ID/EXE register (insert bubble).
REQ-014 freez_back  output  1  hold ID/EXE, EXE/MEM and MEM/WB registers.
REQ-015 hazard_detected  output  1  raw data-hazard indication before priority resolution.
REQ-016 mem_busy  output  1  memory-wait stall active.

Function
REQ-017 Register 0 shall never cause a hazard (dest==0 ignored).
REQ-018 With forward_en=0, hazard_detected shall be 1 when src1 (or src2 if two_regs) equals exe_dest with exe_wb_en=1, or equals mem_dest with mem_wb_en=1.
REQ-019 With forward_en=1, hazard_detected shall be 1 only when src1 (or src2 if two_regs) equals exe_dest with exe_wb_en=1 and exe_mem_read=1.
REQ-020 FSM states: RUN, BUSY, DONE; 8-bit down-counter cnt.
REQ-021 RUN: if (mem_stage_read|mem_stage_write) and MEM_CYCLES>=2, mem_busy=1 this cycle (combinational); next state DONE if MEM_CYCLES==2, else BUSY with cnt<=MEM_CYCLES-3; otherwise stay RUN.
REQ-022 BUSY: mem_busy=1; if cnt==0 next DONE, else cnt<=cnt-1.
REQ-023 DONE: mem_busy=0, memory access detection ignored this cycle; next state RUN unconditionally.
REQ-024 Net effect: a memory instruction shall be held MEM_CYCLES cycles in MEM; with MEM_CYCLES=1 no stall ever occurs and FSM stays RUN.
REQ-025 Priority 1, mem_busy=1: freez_front=1, freez_back=1, flush_ifid=0, flush_idexe=0 (branch_taken and hazards suppressed; they re-evaluate after release since stages are held).
REQ-026 Priority 2, branch_taken=1 (mem_busy=0): flush_ifid=1, flush_idexe=1, freez_front=0, freez_back=0, regardless of hazard_detected.
REQ-027 Priority 3, hazard_detected=1 (no mem_busy, no branch): freez_front=1, flush_idexe=1, flush_ifid=0, freez_back=0.
REQ-028 Otherwise all control outputs 0.
REQ-029 Back-to-back memory instructions shall each get a full MEM_CYCLES stall; the DONE cycle separates them.
REQ-030 Control outputs are combinational from inputs and state; no added latency.

Reset
REQ-031 While reset=1: state RUN, cnt=0, and all outputs forced to 0 irrespective of inputs.
REQ-032 Reset asserted during BUSY or DONE shall abort the stall immediately; after release FSM starts in RUN.

Verification
REQ-033 MEM_CYCLES=4, mem_stage_read=1 at cycle t -> mem_busy/freez_front/freez_back=1 at t,t+1,t+2; 0 at t+3; RUN at t+4.
REQ-034 forward_en=1, exe_mem_read=1, exe_wb_en=1, exe_dest=5, src1=5 -> freez_front=1, flush_idexe=1; same with exe_dest=0 -> all outputs 0.
REQ-035 forward_en=0, mem_wb_en=1, mem_dest=7, src2=7, two_regs=0 -> no hazard; two_regs=1 -> hazard_detected=1, bubble inserted.
REQ-036 branch_taken=1 with concurrent hazard -> flush_ifid=1, flush_idexe=1, freez_front=0; branch_taken=1 during BUSY -> only freezes asserted.
REQ-037 reset pulsed at t+1 of a MEM_CYCLES=4 stall -> outputs 0 during reset; with mem_stage_read still 1 after release, new 3-cycle stall begins.
REQ-038 MEM_CYCLES=1 and 2 builds: continuous mem_stage_write -> never busy (1); busy/not-busy alternating each cycle (2).

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: raw data-hazard detection, branch flush,
// and a multi-cycle memory-wait FSM that freezes the whole pipeline.
module hazard_stall_controller #(
    parameter int MEM_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] src1,
    input  logic [4:0] src2,
    input  logic       two_regs,
    input  logic [4:0] exe_dest,
    input  logic       exe_wb_en,
    input  logic       exe_mem_read,
    input  logic [4:0] mem_dest,
    input  logic       mem_wb_en,
    input  logic       mem_stage_read,
    input  logic       mem_stage_write,
    input  logic       branch_taken,
    input  logic       forward_en,
    output logic       freez_front,
    output logic       flush_ifid,
    output logic       flush_idexe,
    output logic       freez_back,
    output logic       hazard_detected,
    output logic       mem_busy,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The first stalled cycle is spent in RUN and the release cycle in DONE,
    // so BUSY covers the remaining MEM_CYCLES-3 counts plus the cnt==0 cycle.
    localparam logic [7:0] CNT_INIT = (MEM_CYCLES >= 3) ? 8'(MEM_CYCLES - 3) : 8'd0;

    state_t     cur_state;
    state_t     nxt_state;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       busy_raw;
    logic       mem_access;
    logic       exe_hit;
    logic       mem_hit;
    logic       raw_hazard;

    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dest,
                                       input logic wb_en);
        return wb_en && (dest != 5'd0) && (src == dest);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state <= RUN;
            cnt       <= 8'd0;
        end else begin
            cur_state <= nxt_state;
            cnt       <= cnt_nxt;
        end
    end

    assign mem_access = mem_stage_read | mem_stage_write;

    always_comb begin
        nxt_state = cur_state;
        cnt_nxt   = cnt;
        busy_raw  = 1'b0;
        case (cur_state)
            RUN: begin
                if (mem_access && (MEM_CYCLES >= 2)) begin
                    busy_raw = 1'b1;
                    if (MEM_CYCLES == 2) begin
                        nxt_state = DONE;
                    end else begin
                        nxt_state = BUSY;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                busy_raw = 1'b1;
                if (cnt == 8'd0) nxt_state = DONE;
                else             cnt_nxt   = cnt - 8'd1;
            end
            DONE: begin
                // Release cycle: the held instruction leaves MEM, so a still-high
                // access strobe belongs to it and must not restart the stall.
                nxt_state = RUN;
            end
            default: begin
                nxt_state = RUN;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_comb begin
        exe_hit    = reg_match(src1, exe_dest, exe_wb_en) |
                     (two_regs & reg_match(src2, exe_dest, exe_wb_en));
        mem_hit    = reg_match(src1, mem_dest, mem_wb_en) |
                     (two_regs & reg_match(src2, mem_dest, mem_wb_en));
        raw_hazard = forward_en ? (exe_hit & exe_mem_read) : (exe_hit | mem_hit);
    end

    always_comb begin
        freez_front     = 1'b0;
        flush_ifid      = 1'b0;
        flush_idexe     = 1'b0;
        freez_back      = 1'b0;
        hazard_detected = 1'b0;
        mem_busy        = 1'b0;
        if (!reset) begin
            hazard_detected = raw_hazard;
            mem_busy        = busy_raw;
            if (busy_raw) begin
                freez_front = 1'b1;
                freez_back  = 1'b1;
            end else if (branch_taken) begin
                flush_ifid  = 1'b1;
                flush_idexe = 1'b1;
            end else if (raw_hazard) begin
                freez_front = 1'b1;
                flush_idexe = 1'b1;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: three builds (MEM_CYCLES 4, 1, 2) share
// stimulus; a per-cycle model plus hand-computed vectors check the outputs.
module tb_hazard_stall_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] src1, src2, exe_dest, mem_dest;
    logic       two_regs, exe_wb_en, exe_mem_read, mem_wb_en;
    logic       mem_stage_read, mem_stage_write, branch_taken, forward_en;

    // Output vectors: {freez_front, flush_ifid, flush_idexe, freez_back, hazard_detected, mem_busy}
    wire [5:0] vec4, vec1, vec2;
    wire [1:0] st4, st1, st2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    hazard_stall_controller #(.MEM_CYCLES(4)) dut4 (
        .clock(clock), .reset(reset), .src1(src1), .src2(src2), .two_regs(two_regs),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_stage_read(mem_stage_read),
        .mem_stage_write(mem_stage_write), .branch_taken(branch_taken), .forward_en(forward_en),
        .freez_front(vec4[5]), .flush_ifid(vec4[4]), .flush_idexe(vec4[3]),
        .freez_back(vec4[2]), .hazard_detected(vec4[1]), .mem_busy(vec4[0]), .state(st4));

    hazard_stall_controller #(.MEM_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .src1(src1), .src2(src2), .two_regs(two_regs),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_stage_read(mem_stage_read),
        .mem_stage_write(mem_stage_write), .branch_taken(branch_taken), .forward_en(forward_en),
        .freez_front(vec1[5]), .flush_ifid(vec1[4]), .flush_idexe(vec1[3]),
        .freez_back(vec1[2]), .hazard_detected(vec1[1]), .mem_busy(vec1[0]), .state(st1));

    hazard_stall_controller #(.MEM_CYCLES(2)) dut2 (
        .clock(clock), .reset(reset), .src1(src1), .src2(src2), .two_regs(two_regs),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_stage_read(mem_stage_read),
        .mem_stage_write(mem_stage_write), .branch_taken(branch_taken), .forward_en(forward_en),
        .freez_front(vec2[5]), .flush_ifid(vec2[4]), .flush_idexe(vec2[3]),
        .freez_back(vec2[2]), .hazard_detected(vec2[1]), .mem_busy(vec2[0]), .state(st2));

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // occ[k]: which cycle of a memory instruction's MEM residency comes next
    // (0 = no instruction resident). Cycles 1..MC-1 stall, cycle MC releases.
    int mc_of [3] = '{4, 1, 2};
    int occ [3]      = '{0, 0, 0};
    int occ_next [3] = '{0, 0, 0};

    function automatic logic model_hazard();
        logic [4:0] srcs [2];
        int         n;
        logic       hit;
        srcs[0] = src1;
        srcs[1] = src2;
        n   = two_regs ? 2 : 1;
        hit = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (exe_wb_en && exe_dest != 0 && srcs[i] == exe_dest &&
                (!forward_en || exe_mem_read)) hit = 1'b1;
            if (!forward_en && mem_wb_en && mem_dest != 0 && srcs[i] == mem_dest) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic lit(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic       eb;
        logic       hz;
        int         nx;
        logic [5:0] e;
        logic [5:0] a;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            eb = 1'b0;
            nx = 0;
            hz = 1'b0;
            if (!reset) begin
                hz = model_hazard();
                if (occ[k] == 0) begin
                    if ((mem_stage_read || mem_stage_write) && mc_of[k] >= 2) begin
                        eb = 1'b1;
                        nx = 2;
                    end
                end else begin
                    eb = (occ[k] < mc_of[k]);
                    nx = (occ[k] == mc_of[k]) ? 0 : occ[k] + 1;
                end
            end
            occ_next[k] <= nx;
            if (reset)             e = 6'b000000;
            else if (eb)           e = {4'b1001, hz, 1'b1};
            else if (branch_taken) e = {4'b0110, hz, 1'b0};
            else if (hz)           e = 6'b101010;
            else                   e = 6'b000000;
            a = (k == 0) ? vec4 : (k == 1) ? vec1 : vec2;
            lit($sformatf("model_mc%0d", mc_of[k]), a, e);
        end
    end

    always @(posedge clock or posedge reset) begin
        for (int k = 0; k < 3; k++) occ[k] <= reset ? 0 : occ_next[k];
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        src1 = 5'd0; src2 = 5'd0; two_regs = 1'b0;
        exe_dest = 5'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = 5'd0; mem_wb_en = 1'b0;
        mem_stage_read = 1'b0; mem_stage_write = 1'b0;
        branch_taken = 1'b0; forward_en = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk4(input string name, input logic [5:0] exp);
        @(negedge clock);
        lit(name, vec4, exp);
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        mem_stage_read = 1'b1; branch_taken = 1'b1;
        exe_wb_en = 1'b1; exe_dest = 5'd5; src1 = 5'd5;
        chk4("reset_forces_zero", 6'b000000);
        chk4("reset_forces_zero2", 6'b000000);

        reset = 1'b0;
        clear_inputs();
        chk4("idle", 6'b000000);

        // Forwarding active: only a load-use in EXE stalls.
        forward_en = 1'b1; exe_mem_read = 1'b1; exe_wb_en = 1'b1; exe_dest = 5'd5; src1 = 5'd5;
        chk4("load_use_fwd", 6'b101010);
        exe_dest = 5'd0; src1 = 5'd0;
        chk4("load_use_r0", 6'b000000);
        exe_dest = 5'd5; src1 = 5'd5; exe_mem_read = 1'b0;
        chk4("fwd_no_load", 6'b000000);
        clear_inputs();
        forward_en = 1'b1; mem_wb_en = 1'b1; mem_dest = 5'd9; src1 = 5'd9;
        chk4("fwd_mem_dep", 6'b000000);

        // No forwarding: src2 only counts when two_regs is set.
        clear_inputs();
        mem_wb_en = 1'b1; mem_dest = 5'd7; src2 = 5'd7; src1 = 5'd1;
        chk4("src2_ignored", 6'b000000);
        two_regs = 1'b1;
        chk4("src2_hazard", 6'b101010);
        clear_inputs();
        exe_wb_en = 1'b1; exe_dest = 5'd3; src1 = 5'd3;
        chk4("exe_dep_nofwd", 6'b101010);
        branch_taken = 1'b1;
        chk4("branch_over_hazard", 6'b011010);

        // Four-cycle memory stall starting at t.
        clear_inputs();
        mem_stage_read = 1'b1;
        chk4("mem_t", 6'b100101);
        mem_stage_read = 1'b0; branch_taken = 1'b1;
        chk4("mem_t1_branch", 6'b100101);
        exe_wb_en = 1'b1; exe_dest = 5'd3; src1 = 5'd3;
        chk4("mem_t2_hazard", 6'b100111);
        clear_inputs();
        branch_taken = 1'b1; mem_stage_read = 1'b1;
        chk4("mem_t3_release", 6'b011000);
        clear_inputs();
        chk4("mem_t4_run", 6'b000000);

        // Continuous memory traffic on all three builds.
        clear_inputs();
        mem_stage_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic b4;
            logic b2;
            b4 = (i % 4 != 3);
            b2 = (i % 2 == 0);
            @(negedge clock);
            lit("b2b_mc4_busy", {5'b0, vec4[0]}, {5'b0, b4});
            lit("b2b_mc1", vec1, 6'b000000);
            lit("b2b_mc2_busy", {5'b0, vec2[0]}, {5'b0, b2});
            next_cycle();
        end
        clear_inputs();
        chk4("b2b_after", 6'b000000);

        // Reset in the middle of a stall.
        mem_stage_read = 1'b1;
        chk4("rst_stall_t", 6'b100101);
        reset = 1'b1;
        chk4("rst_during_stall", 6'b000000);
        reset = 1'b0;
        chk4("rst_new_stall1", 6'b100101);
        chk4("rst_new_stall2", 6'b100101);
        chk4("rst_new_stall3", 6'b100101);
        chk4("rst_new_release", 6'b000000);
        mem_stage_read = 1'b0;
        chk4("rst_idle", 6'b000000);

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

endmodule
